led_seq_checker: RTL

Observer for the LED shift-register output bus. It watches the LED vector and the step strobe that advances the shift register, and checks that each strobe produces exactly one one-position rotation of a one-hot pattern. It flags any deviation, counts good steps and errors, and presents lock, error and counter status as registered outputs for the debug-probe inputs. It sits beside the shift register in the top level, on the receiving end of the same LED bus and strobe.

---
 rtl/led_seq_checker_pkg.sv | 16 +
 rtl/led_seq_checker_sat_counter.sv | 23 ++
 rtl/led_seq_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_seq_checker_pkg.sv
// Shared definitions for the LED rotation checker: FSM state encoding
// and rotation direction constants.
package led_seq_checker_pkg;

    // 2'd3 is unused and recovers to ST_UNLOCKED.
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_VERIFY   = 2'd2
    } state_t;

    // Rotation direction as seen on i_dir.
    localparam logic DIR_MSB = 1'b0;  // 0001 -> 0010
    localparam logic DIR_LSB = 1'b1;  // 0001 -> 1000

endpackage

// File: rtl/led_seq_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    // Count increments, holding once every bit is set; clear wins over inc.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/led_seq_checker.sv
// Observer for the LED shift-register bus. Locks onto a one-hot pattern,
// then checks that every step strobe yields exactly one circular rotation
// in the requested direction. Errors pulse o_error and bump a saturating
// counter; verified steps bump a wrapping counter.
//
// Handshake: i_valid is a single-cycle strobe with no back-pressure. A
// strobe in cycle N means i_led is compared in cycle N+1 and the result
// appears on the outputs in cycle N+2. Strobes may arrive every cycle.
module led_seq_checker
    import led_seq_checker_pkg::*;
#(
    parameter int NB_LEDS    = 4,
    parameter int NB_STEPCNT = 32,
    parameter int NB_ERRCNT  = 16
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic                  i_dir,
    input  logic [NB_LEDS-1:0]    i_led,
    output logic                  o_locked,
    output logic                  o_error,
    output logic [NB_STEPCNT-1:0] o_step_count,
    output logic [NB_ERRCNT-1:0]  o_err_count,
    output state_t                o_state
);

    localparam logic [NB_LEDS-1:0] LED_ONE = {{(NB_LEDS-1){1'b0}}, 1'b1};

    state_t             state;
    logic [NB_LEDS-1:0] held;
    logic [NB_LEDS-1:0] expected;
    logic               one_hot;
    logic               err_det;
    logic               step_ok;

    // Circular one-position rotation of an LED pattern.
    function automatic logic [NB_LEDS-1:0] rotate(input logic [NB_LEDS-1:0] v,
                                                  input logic dir);
        if (dir == DIR_LSB) begin
            return {v[0], v[NB_LEDS-1:1]};
        end
        return {v[NB_LEDS-2:0], v[NB_LEDS-1]};
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        one_hot = (i_led != '0) && ((i_led & (i_led - LED_ONE)) == '0);
    end

    // Per-cycle verdict: a violation or a verified step; clear discards both.
    always_comb begin
        err_det = 1'b0;
        step_ok = 1'b0;
        if (!i_clear) begin
            case (state)
                ST_LOCKED: err_det = !i_valid && (i_led != held);
                ST_VERIFY: begin
                    err_det = (i_led != expected);
                    step_ok = (i_led == expected);
                end
                default: begin
                    err_det = 1'b0;
                    step_ok = 1'b0;
                end
            endcase
        end
    end

    // Main FSM with registered lock/error status.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_UNLOCKED;
            held     <= '0;
            expected <= '0;
            o_locked <= 1'b0;
            o_error  <= 1'b0;
        end else if (i_clear) begin
            state    <= ST_UNLOCKED;
            o_locked <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            o_error <= err_det;
            case (state)
                ST_UNLOCKED: begin
                    if (one_hot) begin
                        held     <= i_led;
                        state    <= ST_LOCKED;
                        o_locked <= 1'b1;
                    end else begin
                        o_locked <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (i_valid) begin
                        expected <= rotate(held, i_dir);
                        state    <= ST_VERIFY;
                        o_locked <= 1'b1;
                    end else if (err_det) begin
                        state    <= ST_UNLOCKED;
                        o_locked <= 1'b0;
                    end else begin
                        o_locked <= 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (step_ok) begin
                        held     <= i_led;
                        o_locked <= 1'b1;
                        if (i_valid) begin
                            expected <= rotate(i_led, i_dir);
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end else begin
                        state    <= ST_UNLOCKED;
                        o_locked <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_UNLOCKED;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

    // Verified-step counter, wraps silently.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_step_count <= '0;
        end else if (i_clear) begin
            o_step_count <= '0;
        end else if (step_ok) begin
            o_step_count <= o_step_count + NB_STEPCNT'(1);
        end
    end

    sat_counter #(
        .W (NB_ERRCNT)
    ) u_err_cnt (
        .clock   (clock),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_inc   (err_det),
        .o_count (o_err_count)
    );

    assign o_state = state;

endmodule
